// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// The stage FSM tracks how many of its two entries are valid.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  localparam int OCC_W = 2;

  // Each control bit of a bubble is driven to this value (NOP encoding).
  localparam logic BUBBLE_BIT = 1'b0;

  function automatic logic [OCC_W-1:0] occ_of(input stage_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Handshake, payload and status bundle of one elastic stage.
// The master side is the environment; the slave side is the stage.
interface pipe_stage_elastic_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) ();

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cnt
  );

endinterface

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Up-counter that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count enabled cycles until the counter is full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {W{1'b0}};
    end else if (en && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main + skid entry, registered ready and outputs,
// flush with bubble insertion and a saturating upstream stall counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = 8,
  parameter int                DATA_W      = 128,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{BUBBLE_BIT}},
  parameter int                CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  pipe_stage_elastic_if.slave bus
);

  stage_state_t      state_r, state_s;
  logic [CTRL_W-1:0] main_ctrl_r, main_ctrl_s, skid_ctrl_r, skid_ctrl_s;
  logic [DATA_W-1:0] main_data_r, main_data_s, skid_data_r, skid_data_s;
  logic [CTRL_W-1:0] out_ctrl_r, out_ctrl_s;
  logic              in_ready_r, out_valid_r;
  logic [OCC_W-1:0]  occ_r;
  logic [CNT_W-1:0]  stall_cnt_s;
  logic              in_fire_s, out_fire_s;

  assign in_fire_s  = bus.in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & bus.out_ready;

  // Next state and entry updates; flush overrides any handshake.
  always_comb begin
    state_s     = state_r;
    main_ctrl_s = main_ctrl_r;
    main_data_s = main_data_r;
    skid_ctrl_s = skid_ctrl_r;
    skid_data_s = skid_data_r;
    if (bus.flush) begin
      state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_s     = ONE;
            main_ctrl_s = bus.in_ctrl;
            main_data_s = bus.in_data;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && !out_fire_s) begin
            state_s     = TWO;
            skid_ctrl_s = bus.in_ctrl;
            skid_data_s = bus.in_data;
          end else if (in_fire_s) begin
            state_s     = ONE;
            main_ctrl_s = bus.in_ctrl;
            main_data_s = bus.in_data;
          end else if (out_fire_s) begin
            state_s = EMPTY;
          end else begin
            state_s = ONE;
          end
        end
        TWO: begin
          if (out_fire_s) begin
            state_s     = ONE;
            main_ctrl_s = skid_ctrl_r;
            main_data_s = skid_data_r;
          end else begin
            state_s = TWO;
          end
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end
    out_ctrl_s = (state_s != EMPTY) ? main_ctrl_s : BUBBLE_CTRL;
  end

  // State, entries and all outward-facing flags are registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= EMPTY;
      main_ctrl_r <= {CTRL_W{1'b0}};
      main_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
      out_ctrl_r  <= BUBBLE_CTRL;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      occ_r       <= {OCC_W{1'b0}};
    end else begin
      state_r     <= state_s;
      main_ctrl_r <= main_ctrl_s;
      main_data_r <= main_data_s;
      skid_ctrl_r <= skid_ctrl_s;
      skid_data_r <= skid_data_s;
      out_ctrl_r  <= out_ctrl_s;
      in_ready_r  <= (state_s != TWO);
      out_valid_r <= (state_s != EMPTY);
      occ_r       <= occ_of(state_s);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (bus.in_valid & ~in_ready_r),
    .count   (stall_cnt_s)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_ctrl  = out_ctrl_r;
  assign bus.out_data  = main_data_r;
  assign bus.occupancy = occ_r;
  assign bus.stall_cnt = stall_cnt_s;

endmodule
